// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
// Raster timing generator for the pixel-colour stage. A clock divider produces
// a one-clock pixel_en strobe every CLOCK_DIV system clocks; on each strobe the
// horizontal/vertical scan counters advance one pixel. Sync, blank and the
// line/frame strobes are decoded combinationally from the counter registers, so
// they are valid for the whole pixel period that follows a pixel_en clock.
//
// Ports
//   clock        in   1  system clock, all state on rising edge
//   reset_       in   1  asynchronous reset, active low
//   run          in   1  1 = timing advances, 0 = all state frozen
//   pixel_en     out  1  one-clock strobe per pixel
//   video_x      out  9  horizontal position, 0..H_TOTAL-1
//   video_y      out  9  vertical position, 0..V_TOTAL-1
//   hsync_       out  1  horizontal sync, active low
//   vsync_       out  1  vertical sync, active low
//   blank        out  1  high outside the visible area
//   line_start   out  1  pixel_en at video_x == 0
//   frame_start  out  1  pixel_en at video_x == 0 and video_y == 0
//   frame_count  out  8  frames completed, wraps 255 -> 0
// -----------------------------------------------------------------------------
module video_timing #(
   parameter int unsigned CLOCK_DIV = 32'd2,
   parameter int unsigned H_ACTIVE  = 32'd320,
   parameter int unsigned H_FRONT   = 32'd16,
   parameter int unsigned H_SYNC    = 32'd32,
   parameter int unsigned H_BACK    = 32'd48,
   parameter int unsigned V_ACTIVE  = 32'd240,
   parameter int unsigned V_FRONT   = 32'd4,
   parameter int unsigned V_SYNC    = 32'd4,
   parameter int unsigned V_BACK    = 32'd16
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic       run,
   output logic       pixel_en,
   output logic [8:0] video_x,
   output logic [8:0] video_y,
   output logic       hsync_,
   output logic       vsync_,
   output logic       blank,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Reject geometries the 9-bit counters or 4-bit divider cannot represent.
   if (CLOCK_DIV == 32'd0 || CLOCK_DIV > 32'd16 ||
       H_ACTIVE == 32'd0 || H_FRONT == 32'd0 || H_SYNC == 32'd0 || H_BACK == 32'd0 ||
       V_ACTIVE == 32'd0 || V_FRONT == 32'd0 || V_SYNC == 32'd0 || V_BACK == 32'd0 ||
       H_TOTAL > 32'd512 || V_TOTAL > 32'd512) begin : g_bad_cfg
      $fatal(1, "video_timing: illegal timing parameters");
   end

   localparam logic [3:0] DIV_LAST = 4'(CLOCK_DIV - 32'd1);
   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 32'd1);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 32'd1);
   localparam logic [8:0] H_VIS    = 9'(H_ACTIVE);
   localparam logic [8:0] V_VIS    = 9'(V_ACTIVE);
   localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FRONT);
   localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [8:0] VS_START = 9'(V_ACTIVE + V_FRONT);
   localparam logic [8:0] VS_END   = 9'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [3:0] div_r;
   logic [8:0] x_r;
   logic [8:0] y_r;
   logic [7:0] frame_cnt_r;
   logic       pixel_en_s;
   logic       hsync_n_s;
   logic       vsync_n_s;
   logic       blank_s;
   logic       line_start_s;
   logic       frame_start_s;

   // The strobe is decoded from the divider so the first pixel after reset
   // release is issued with no wait.
   assign pixel_en_s = run & (div_r == 4'd0);

   // Pixel clock divider: counts only while running so a pause loses no pixel.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         div_r <= 4'd0;
      end else if (run) begin
         if (div_r == DIV_LAST) begin
            div_r <= 4'd0;
         end else begin
            div_r <= div_r + 4'd1;
         end
      end
   end

   // Scan position and frame counter, advanced once per pixel strobe.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         x_r         <= 9'd0;
         y_r         <= 9'd0;
         frame_cnt_r <= 8'd0;
      end else if (pixel_en_s) begin
         if (x_r == H_LAST) begin
            x_r <= 9'd0;
            if (y_r == V_LAST) begin
               y_r         <= 9'd0;
               frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
               y_r <= y_r + 9'd1;
            end
         end else begin
            x_r <= x_r + 9'd1;
         end
      end
   end

   // Sync, blank and strobe decode from the counter registers.
   always_comb begin
      hsync_n_s     = 1'b1;
      vsync_n_s     = 1'b1;
      blank_s       = 1'b0;
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;

      if (x_r >= HS_START && x_r < HS_END) begin
         hsync_n_s = 1'b0;
      end else begin
         hsync_n_s = 1'b1;
      end

      if (y_r >= VS_START && y_r < VS_END) begin
         vsync_n_s = 1'b0;
      end else begin
         vsync_n_s = 1'b1;
      end

      if (x_r >= H_VIS || y_r >= V_VIS) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end

      if (pixel_en_s && x_r == 9'd0) begin
         line_start_s  = 1'b1;
         frame_start_s = (y_r == 9'd0);
      end else begin
         line_start_s  = 1'b0;
         frame_start_s = 1'b0;
      end
   end

   assign pixel_en    = pixel_en_s;
   assign video_x     = x_r;
   assign video_y     = y_r;
   assign hsync_      = hsync_n_s;
   assign vsync_      = vsync_n_s;
   assign blank       = blank_s;
   assign line_start  = line_start_s;
   assign frame_start = frame_start_s;
   assign frame_count = frame_cnt_r;

endmodule

// File: tb/tb_video_timing.sv
// -----------------------------------------------------------------------------
// tb_video_timing
// Directed bench. u_dut uses the default 416x264 geometry with CLOCK_DIV=2 for
// line-level behaviour, pause and mid-line reset. u_small uses a 7x5 raster
// with CLOCK_DIV=1 so vertical sync and frame_count wrap fit in a short run.
// -----------------------------------------------------------------------------
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_video_timing;

   logic       clock;
   logic       reset_;
   logic       run;
   logic       pixel_en;
   logic [8:0] video_x;
   logic [8:0] video_y;
   logic       hsync_;
   logic       vsync_;
   logic       blank;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;

   logic       s_reset_;
   logic       s_run;
   logic       s_pixel_en;
   logic [8:0] s_x;
   logic [8:0] s_y;
   logic       s_hsync_;
   logic       s_vsync_;
   logic       s_blank;
   logic       s_line_start;
   logic       s_frame_start;
   logic [7:0] s_frame_count;

   int checks   = 0;
   int failures = 0;
   int k_big    = 0;
   int k_small  = 0;
   int cnt_a;
   int cnt_b;

   video_timing u_dut (
      .clock       (clock),
      .reset_      (reset_),
      .run         (run),
      .pixel_en    (pixel_en),
      .video_x     (video_x),
      .video_y     (video_y),
      .hsync_      (hsync_),
      .vsync_      (vsync_),
      .blank       (blank),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   video_timing #(
      .CLOCK_DIV (32'd1),
      .H_ACTIVE  (32'd4), .H_FRONT (32'd1), .H_SYNC (32'd1), .H_BACK (32'd1),
      .V_ACTIVE  (32'd2), .V_FRONT (32'd1), .V_SYNC (32'd1), .V_BACK (32'd1)
   ) u_small (
      .clock       (clock),
      .reset_      (s_reset_),
      .run         (s_run),
      .pixel_en    (s_pixel_en),
      .video_x     (s_x),
      .video_y     (s_y),
      .hsync_      (s_hsync_),
      .vsync_      (s_vsync_),
      .blank       (s_blank),
      .line_start  (s_line_start),
      .frame_start (s_frame_start),
      .frame_count (s_frame_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to the negedge following rising edge number 'target' since release.
   task automatic adv(inout int cnt, input int target);
      repeat (target - cnt) @(negedge clock);
      cnt = target;
   endtask

   initial begin
      reset_   = 1'b0;
      run      = 1'b1;
      s_reset_ = 1'b0;
      s_run    = 1'b1;
      repeat (3) @(negedge clock);

      // ---- reset state ----
      `CHK("rst_x", video_x, 0);
      `CHK("rst_y", video_y, 0);
      `CHK("rst_hsync", hsync_, 1);
      `CHK("rst_vsync", vsync_, 1);
      `CHK("rst_blank", blank, 0);
      `CHK("rst_fcount", frame_count, 0);
      `CHK("rst_pix_en", pixel_en, 1);

      // ---- release: first pixel is immediate ----
      reset_ = 1'b1;
      #1;
      `CHK("rel_pix_en", pixel_en, 1);
      `CHK("rel_fstart", frame_start, 1);
      `CHK("rel_lstart", line_start, 1);
      `CHK("rel_x", video_x, 0);
      `CHK("rel_y", video_y, 0);

      adv(k_big, 1);
      `CHK("k1_x", video_x, 1);
      `CHK("k1_pix_en", pixel_en, 0);
      `CHK("k1_fstart", frame_start, 0);
      adv(k_big, 2);
      `CHK("k2_x", video_x, 1);
      `CHK("k2_pix_en", pixel_en, 1);
      `CHK("k2_lstart", line_start, 0);

      // ---- horizontal windows ----
      adv(k_big, 637);
      `CHK("x319_x", video_x, 319);
      `CHK("x319_blank", blank, 0);
      adv(k_big, 639);
      `CHK("x320_x", video_x, 320);
      `CHK("x320_blank", blank, 1);
      `CHK("x320_hsync", hsync_, 1);
      adv(k_big, 669);
      `CHK("x335_hsync", hsync_, 1);
      adv(k_big, 671);
      `CHK("x336_x", video_x, 336);
      `CHK("x336_hsync", hsync_, 0);
      adv(k_big, 733);
      `CHK("x367_hsync", hsync_, 0);
      adv(k_big, 735);
      `CHK("x368_x", video_x, 368);
      `CHK("x368_hsync", hsync_, 1);

      // ---- end of line and wrap ----
      adv(k_big, 830);
      `CHK("x415_x", video_x, 415);
      `CHK("x415_y", video_y, 0);
      `CHK("x415_pix_en", pixel_en, 1);
      adv(k_big, 831);
      `CHK("wrap_x", video_x, 0);
      `CHK("wrap_y", video_y, 1);
      `CHK("wrap_lstart", line_start, 0);
      adv(k_big, 832);
      `CHK("l1_lstart", line_start, 1);
      `CHK("l1_fstart", frame_start, 0);
      `CHK("l1_blank", blank, 0);

      // ---- one full line: strobe and sync counts ----
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 832; i++) begin
         @(negedge clock);
         if (line_start) cnt_a++;
         if (!hsync_) cnt_b++;
      end
      k_big += 832;
      `CHK("line_lstart_cnt", cnt_a, 1);
      `CHK("line_hsync_clks", cnt_b, 64);
      `CHK("l2_x", video_x, 0);
      `CHK("l2_y", video_y, 2);

      // ---- pause at video_x = 100 ----
      adv(k_big, 1864);
      `CHK("p_x", video_x, 100);
      `CHK("p_pix_en", pixel_en, 1);
      run = 1'b0;
      #1;
      `CHK("p_pix_en_off", pixel_en, 0);
      cnt_a = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (pixel_en || line_start || frame_start) cnt_a++;
         checks++;
         if (video_x !== 9'd100) begin
            failures++;
            $error("FAIL p_loop_x observed=%0d expected=100", video_x);
         end
         checks++;
         if (video_y !== 9'd2) begin
            failures++;
            $error("FAIL p_loop_y observed=%0d expected=2", video_y);
         end
      end
      `CHK("p_strobes", cnt_a, 0);
      `CHK("p_hold_x", video_x, 100);
      `CHK("p_hold_y", video_y, 2);
      run = 1'b1;
      #1;
      `CHK("p_resume_pix_en", pixel_en, 1);
      `CHK("p_resume_x", video_x, 100);
      @(negedge clock);
      `CHK("p_next_x", video_x, 101);
      `CHK("p_next_pix_en", pixel_en, 0);

      // ---- asynchronous reset mid-line ----
      repeat (198) @(negedge clock);
      `CHK("r_pre_x", video_x, 200);
      `CHK("r_pre_y", video_y, 2);
      reset_ = 1'b0;
      #1;
      `CHK("r_async_x", video_x, 0);
      `CHK("r_async_y", video_y, 0);
      `CHK("r_async_fcount", frame_count, 0);
      `CHK("r_async_blank", blank, 0);
      @(negedge clock);
      reset_ = 1'b1;
      #1;
      `CHK("r_rel_fstart", frame_start, 1);
      @(negedge clock);
      `CHK("r_next_x", video_x, 1);
      `CHK("r_next_y", video_y, 0);

      // ---- small raster: vertical windows and frame wrap ----
      s_reset_ = 1'b1;
      #1;
      `CHK("s0_fstart", s_frame_start, 1);
      `CHK("s0_x", s_x, 0);
      adv(k_small, 5);
      `CHK("s5_hsync", s_hsync_, 0);
      adv(k_small, 6);
      `CHK("s6_x", s_x, 6);
      `CHK("s6_hsync", s_hsync_, 1);
      `CHK("s6_blank", s_blank, 1);
      adv(k_small, 14);
      `CHK("s_y2_y", s_y, 2);
      `CHK("s_y2_vsync", s_vsync_, 1);
      `CHK("s_y2_blank", s_blank, 1);
      adv(k_small, 21);
      `CHK("s_y3_y", s_y, 3);
      `CHK("s_y3_vsync", s_vsync_, 0);
      adv(k_small, 28);
      `CHK("s_y4_vsync", s_vsync_, 1);
      adv(k_small, 34);
      `CHK("s_last_x", s_x, 6);
      `CHK("s_last_y", s_y, 4);
      `CHK("s_last_fstart", s_frame_start, 0);
      adv(k_small, 35);
      `CHK("s_f1_x", s_x, 0);
      `CHK("s_f1_y", s_y, 0);
      `CHK("s_f1_fstart", s_frame_start, 1);
      `CHK("s_f1_fcount", s_frame_count, 1);

      cnt_a = 0;
      for (int i = 0; i < 8890; i++) begin
         @(negedge clock);
         if (s_frame_start) cnt_a++;
      end
      k_small += 8890;
      `CHK("s_fstart_cnt", cnt_a, 254);
      `CHK("s_f255_fcount", s_frame_count, 255);
      `CHK("s_f255_fstart", s_frame_start, 1);
      adv(k_small, 8959);
      `CHK("s_pre_wrap_fcount", s_frame_count, 255);
      `CHK("s_pre_wrap_x", s_x, 6);
      adv(k_small, 8960);
      `CHK("s_wrap_fcount", s_frame_count, 0);
      `CHK("s_wrap_fstart", s_frame_start, 1);
      `CHK("s_wrap_y", s_y, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
